// File: rtl/mm_pkg.sv
// Shared types and helpers for the int8 requantize-and-pack output stage.
// Latency: n/a (types, constants and a combinational requant function).
// Backpressure: n/a.
package mm_pkg;

  localparam int LANES_IN  = 2;
  localparam int LANES_OUT = 4;
  localparam int ACC_W     = 16;
  localparam int Q_W       = 8;

  // Saturation bounds held at the widened (ACC_W+1) precision used inside requant.
  localparam logic signed [ACC_W:0] Q_MAX_EXT = (ACC_W+1)'(2**(Q_W-1) - 1);
  localparam logic signed [ACC_W:0] Q_MIN_EXT = (ACC_W+1)'(-(2**(Q_W-1)));

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } state_t;

  // Sign-extend one bit so the rounding bias can never wrap a large positive
  // accumulator, shift arithmetically, then clamp to the int8 range.
  function automatic logic [Q_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                              input int               shift,
                                              input logic             round);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] sh;
    ext  = signed'({acc[ACC_W-1], acc});
    bias = '0;
    if (round && (shift > 0)) begin
      bias = (ACC_W+1)'(1) << (shift - 1);
    end
    sh = (ext + bias) >>> shift;
    if (sh > Q_MAX_EXT) begin
      return Q_MAX_EXT[Q_W-1:0];
    end else if (sh < Q_MIN_EXT) begin
      return Q_MIN_EXT[Q_W-1:0];
    end
    return sh[Q_W-1:0];
  endfunction

endpackage

// File: rtl/mm_requant_lane.sv
// One accumulator lane requantized to a saturated int8.
// Latency: combinational.
// Backpressure: none; purely combinational.
module mm_requant_lane
  import mm_pkg::*;
#(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 16,
  parameter int SHIFT   = 4,
  parameter int ROUND   = 1
) (
  input  logic [D_W_ACC-1:0] in,
  output logic [D_W-1:0]     out
);

  assign out = requant(in, SHIFT, (ROUND != 0));

endmodule

// File: rtl/mm_requant_pack.sv
// Requantizes two int16 lanes per input beat to int8 and packs four per output beat.
// Latency: output beat valid one cycle after the accept that completes or flushes a word.
// Backpressure: x_TREADY = !y_TVALID || y_TREADY; a held output word stalls the input.
module mm_requant_pack
  import mm_pkg::*;
#(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 16,
  parameter int SHIFT   = 4,
  parameter int ROUND   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x_TDATA,
  input  logic        x_TVALID,
  output logic        x_TREADY,
  input  logic        x_TLAST,
  output logic [31:0] y_TDATA,
  output logic        y_TVALID,
  input  logic        y_TREADY,
  output logic        y_TLAST
);

  state_t             state, state_nxt;
  logic [2*D_W-1:0]   half, half_nxt;
  logic [31:0]        y_dat_nxt;
  logic               y_vld_nxt;
  logic               y_last_nxt;
  logic [D_W-1:0]     q0, q1;
  logic               x_acc;

  // Ready depends only on the output register so it never loops back through x_TVALID.
  assign x_TREADY = !y_TVALID || y_TREADY;
  assign x_acc    = x_TVALID && x_TREADY;

  mm_requant_lane #(.D_W(D_W), .D_W_ACC(D_W_ACC), .SHIFT(SHIFT), .ROUND(ROUND)) u_lane0 (
    .in  (x_TDATA[D_W_ACC-1:0]),
    .out (q0)
  );

  mm_requant_lane #(.D_W(D_W), .D_W_ACC(D_W_ACC), .SHIFT(SHIFT), .ROUND(ROUND)) u_lane1 (
    .in  (x_TDATA[2*D_W_ACC-1:D_W_ACC]),
    .out (q1)
  );

  // Next-state: hold the low half in LO, complete the word in HI, flush early on TLAST in LO.
  always_comb begin
    state_nxt  = state;
    half_nxt   = half;
    y_dat_nxt  = y_TDATA;
    y_last_nxt = y_TLAST;
    y_vld_nxt  = y_TVALID && !y_TREADY;
    if (x_acc) begin
      case (state)
        LO: begin
          if (x_TLAST) begin
            y_dat_nxt  = {{(2*D_W){1'b0}}, q1, q0};
            y_last_nxt = 1'b1;
            y_vld_nxt  = 1'b1;
          end else begin
            half_nxt  = {q1, q0};
            state_nxt = HI;
          end
        end
        HI: begin
          y_dat_nxt  = {q1, q0, half};
          y_last_nxt = x_TLAST;
          y_vld_nxt  = 1'b1;
          state_nxt  = LO;
        end
        default: state_nxt = LO;
      endcase
    end
  end

  // State, half-word and output registers; reset drops any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LO;
      half     <= '0;
      y_TDATA  <= '0;
      y_TVALID <= 1'b0;
      y_TLAST  <= 1'b0;
    end else begin
      state    <= state_nxt;
      half     <= half_nxt;
      y_TDATA  <= y_dat_nxt;
      y_TVALID <= y_vld_nxt;
      y_TLAST  <= y_last_nxt;
    end
  end

endmodule

// File: doc/mm_requant_pack.md
# mm_requant_pack

Output post-processing stage that sits directly downstream of the matrix-multiply AXI-Stream wrapper and consumes its 32-bit result stream. Each input beat carries two signed 16-bit accumulator results. The block requantizes each result to a signed 8-bit value (arithmetic right shift, optional round-half-up, saturation) and packs four 8-bit results into each 32-bit output beat. Packet boundaries are preserved through TLAST, which lets the DMA return int8 matrices at half the accumulator bandwidth.

## Interface
Parameters:
- D_W, default 8: output element width; the block is fixed at four elements per 32-bit beat.
- D_W_ACC, default 16: input accumulator width; the block is fixed at two lanes per 32-bit beat.
- SHIFT, default 4: right-shift amount; legal range 1..D_W_ACC-1.
- ROUND, default 1: 1 adds 2^(SHIFT-1) before the shift; 0 truncates toward negative infinity.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: reset, synchronous and active-high.
- x_TDATA, input, 32: lane0 = [15:0], lane1 = [31:16], both two's complement.
- x_TVALID, input, 1: input beat valid.
- x_TREADY, output, 1: input beat accepted when x_TVALID and x_TREADY are both high.
- x_TLAST, input, 1: last beat of the packet.
- y_TDATA, output, 32: four packed int8 results.
- y_TVALID, output, 1: output beat valid.
- y_TREADY, input, 1: downstream ready.
- y_TLAST, output, 1: last beat of the output packet.

## Operation
- Requantization of each lane:
  - Sign-extend the lane to D_W_ACC+1 bits.
  - If ROUND=1, add 2^(SHIFT-1). The extra bit prevents overflow.
  - Arithmetic-shift right by SHIFT.
  - Saturate to the range [-128, 127].
- The state machine has two states, LO and HI. Its registers are a half-word register (2 bytes), the output data register, y_TVALID and y_TLAST.
- LO, on accept with x_TLAST=0:
  - Store the requantized lane0 and lane1 as the low half.
  - Go to HI.
- LO, on accept with x_TLAST=1 (flush):
  - Load the output register with {8'h00, 8'h00, q(lane1), q(lane0)}.
  - Set y_TLAST=1 and y_TVALID=1.
  - Stay in LO.
- HI, on accept:
  - Load the output register with {q(lane1), q(lane0), half[15:8], half[7:0]}.
  - Set y_TLAST = x_TLAST and y_TVALID=1.
  - Go to LO.
- Byte order per output beat: byte0 and byte1 come from the first input beat (lane0, lane1); byte2 and byte3 come from the second input beat.
- x_TREADY = !y_TVALID || y_TREADY in both states. It is never combinationally dependent on x_TVALID or x_TLAST.
- y_TVALID clears on a y handshake unless a new beat is loaded in the same cycle. A simultaneous y handshake and x accept that loads the output register yields back-to-back output beats.
- Once asserted, y_TVALID must not drop and y_TDATA/y_TLAST must not change until the y handshake.
- Reset values: y_TVALID=0, y_TLAST=0, y_TDATA=0, state=LO, half register=0. x_TREADY is therefore 1 after reset.
- Reset mid-packet discards any held half-word and any pending output beat.

## Timing
- Output latency: y_TVALID rises on the cycle after the accept of the beat that completes (or flushes) an output word.
- Throughput: one input beat per cycle, one output beat per two input beats, provided y_TREADY stays high.
- All outputs are registered except x_TREADY, which is one gate from y_TVALID/y_TREADY.

## Structure
- Shared package `mm_pkg`:
  - Constants LANES_IN=2, LANES_OUT=4.
  - The function `requant(acc, shift, round)` returning the saturated int8.
  - The enum for states LO/HI.
- Sub-module `mm_requant_lane`: purely combinational, instantiated twice (lane0, lane1). Parameters SHIFT and ROUND; ports in [D_W_ACC-1:0], out [D_W-1:0].

## Test plan
Unless noted, all scenarios use SHIFT=4 and ROUND=1.
- Pair conversion: input beats 0x7FFF_0018 then 0xFFE8_8000 (TLAST on the second) -> y_TDATA=0xFF80_7F02, y_TLAST=1, y_TVALID one cycle after the second accept.
- Odd-length flush: a single beat 0x0010_0020 with TLAST -> y_TDATA=0x0000_0102, y_TLAST=1, and the next beat starts in LO.
- Backpressure: hold y_TREADY=0 for 5 cycles with y_TVALID high -> y_TDATA and y_TLAST stable, x_TREADY=0, no beats lost or duplicated, 64 random beats matching the reference model.
- Streaming: 64 back-to-back beats with y_TREADY=1 -> 32 output beats, x_TREADY held at 1 throughout, y_TLAST only on the 32nd.
- Reset mid-packet: assert rst after one beat is accepted -> next cycle y_TVALID=0 and state LO; a following pair produces only the new data.
- ROUND=0 build: lane 0xFFE8 -> 0xFE; lane 0x0018 -> 0x01.
